// File: rtl/regfile_wport_arbiter.sv
// Register-file write-port arbiter: the writeback stage has priority, long-latency results
// queue in a small FIFO, and a starvation timer forces a pipeline stall so the FIFO drains.
module regfile_wport_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wb_enable,
  input  logic [4:0]                   wb_addr,
  input  logic [31:0]                  wb_data,
  input  logic                         lu_valid,
  output logic                         lu_ready,
  input  logic [4:0]                   lu_addr,
  input  logic [31:0]                  lu_data,
  output logic                         pipe_stall,
  output logic                         rf_we,
  output logic [4:0]                   rf_waddr,
  output logic [31:0]                  rf_wdata,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [4:0]          mem_addr [DEPTH];
  logic [31:0]         mem_data [DEPTH];

  logic full, empty, wb_live, push, pop, blocked;

  assign fifo_count = count_q;

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    wb_live  = wb_enable && (wb_addr != '0);
    lu_ready = !rst && !full;
    // Handshakes to x0 complete but are never enqueued.
    push     = lu_valid && lu_ready && (lu_addr != '0);

    pop      = 1'b0;
    blocked  = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!rst) begin
      if (state_q == IDLE && wb_live) begin
        rf_we    = 1'b1;
        rf_waddr = wb_addr;
        rf_wdata = wb_data;
        blocked  = !empty;
      end else if (!empty) begin
        rf_we    = 1'b1;
        rf_waddr = mem_addr[rd_ptr];
        rf_wdata = mem_data[rd_ptr];
        pop      = 1'b1;
      end
    end
    pipe_stall = !rst && (state_q == DRAIN);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      IDLE: begin
        if (blocked) begin
          if (wait_q == WAIT_W'(MAX_WAIT - 1)) state_d = DRAIN;
          else                                 wait_d  = wait_q + WAIT_W'(1);
        end
      end
      DRAIN: begin
        if (count_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      wait_q  <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wait_q  <= wait_d;
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= lu_addr;
      mem_data[wr_ptr] <= lu_data;
    end
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Cycle-by-cycle vector bench for regfile_wport_arbiter; expected register-file writes are
// queued when stimulus is applied and matched against each observed rf write.
module tb_regfile_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_enable;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  fifo_count;

  regfile_wport_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
    .pipe_stall(pipe_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    logic        erdy;
    logic        estall;
    int          ecnt;   // -1: count not checked on this cycle
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] sb [$];
  vec_t tbl [$];

  function automatic vec_t mk(logic r, logic we, logic [4:0] wa, logic [31:0] wd,
                              logic lv, logic [4:0] la, logic [31:0] ld,
                              logic ewe, logic [4:0] ewa, logic [31:0] ewd,
                              logic erdy, logic estall, int ecnt);
    vec_t v;
    v.rst = r; v.we = we; v.wa = wa; v.wd = wd; v.lv = lv; v.la = la; v.ld = ld;
    v.ewe = ewe; v.ewa = ewa; v.ewd = ewd; v.erdy = erdy; v.estall = estall; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input vec_t t);
    logic [36:0] e;
    rst = t.rst; wb_enable = t.we; wb_addr = t.wa; wb_data = t.wd;
    lu_valid = t.lv; lu_addr = t.la; lu_data = t.ld;
    if (t.ewe) sb.push_back({t.ewa, t.ewd});
    @(negedge clk);
    chk("rf_we", 32'(rf_we), 32'(t.ewe));
    chk("lu_ready", 32'(lu_ready), 32'(t.erdy));
    chk("pipe_stall", 32'(pipe_stall), 32'(t.estall));
    if (t.ecnt >= 0) chk("fifo_count", 32'(fifo_count), 32'(t.ecnt));
    if (t.rst) begin
      chk("rst_waddr", 32'(rf_waddr), 32'd0);
      chk("rst_wdata", rf_wdata, 32'd0);
    end
    if (rf_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(rf_waddr), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("rf_waddr", 32'(rf_waddr), 32'(e[36:32]));
        chk("rf_wdata", rf_wdata, e[31:0]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wb_enable = 1'b0; wb_addr = '0; wb_data = '0;
    lu_valid = 1'b0; lu_addr = '0; lu_data = '0;

    // reset, with requests present that must be suppressed
    tbl.push_back(mk(1, 1,5,32'h1, 1,3,32'h3,       0,0,0,          0,0,-1));
    tbl.push_back(mk(1, 0,0,0,     0,0,0,           0,0,0,          0,0,0));
    tbl.push_back(mk(0, 0,0,0,     0,0,0,           0,0,0,          1,0,0));
    // primary write, zero latency
    tbl.push_back(mk(0, 1,5,32'hDEADBEEF, 0,0,0,    1,5,32'hDEADBEEF, 1,0,0));
    // single secondary push, written one cycle later
    tbl.push_back(mk(0, 0,0,0,     1,7,32'h1234,    0,0,0,          1,0,0));
    tbl.push_back(mk(0, 0,0,0,     0,0,0,           1,7,32'h1234,   1,0,1));
    tbl.push_back(mk(0, 0,0,0,     0,0,0,           0,0,0,          1,0,0));
    // head blocked four cycles by primary traffic, then one DRAIN cycle
    tbl.push_back(mk(0, 1,1,32'h100, 1,9,32'hAA,    1,1,32'h100,    1,0,0));
    tbl.push_back(mk(0, 1,2,32'h101, 0,0,0,         1,2,32'h101,    1,0,1));
    tbl.push_back(mk(0, 1,3,32'h102, 0,0,0,         1,3,32'h102,    1,0,1));
    tbl.push_back(mk(0, 1,4,32'h103, 0,0,0,         1,4,32'h103,    1,0,1));
    tbl.push_back(mk(0, 1,5,32'h104, 0,0,0,         1,5,32'h104,    1,0,1));
    tbl.push_back(mk(0, 1,6,32'h105, 0,0,0,         1,9,32'hAA,     1,1,1));
    tbl.push_back(mk(0, 1,6,32'h105, 0,0,0,         1,6,32'h105,    1,0,0));
    // x0 primary does not block the head; x0 secondary is discarded
    tbl.push_back(mk(0, 0,0,0,     1,11,32'h55,     0,0,0,          1,0,0));
    tbl.push_back(mk(0, 1,0,32'hFFFF, 0,0,0,        1,11,32'h55,    1,0,1));
    tbl.push_back(mk(0, 0,0,0,     1,0,32'h77,      0,0,0,          1,0,0));
    tbl.push_back(mk(0, 0,0,0,     0,0,0,           0,0,0,          1,0,0));
    // simultaneous push and pop keep the count
    tbl.push_back(mk(0, 0,0,0,     1,12,32'h66,     0,0,0,          1,0,0));
    tbl.push_back(mk(0, 0,0,0,     1,13,32'h67,     1,12,32'h66,    1,0,1));
    tbl.push_back(mk(0, 0,0,0,     0,0,0,           1,13,32'h67,    1,0,1));
    tbl.push_back(mk(0, 0,0,0,     0,0,0,           0,0,0,          1,0,0));

    @(posedge clk); #1;
    foreach (tbl[i]) step(tbl[i]);

    // full FIFO: third push is held off until DRAIN frees a slot, all drain in order
    step(mk(0, 1,1,32'h200, 1,20,32'hA0,  1,1,32'h200,  1,0,0));
    step(mk(0, 1,2,32'h201, 1,21,32'hA1,  1,2,32'h201,  1,0,1));
    step(mk(0, 1,3,32'h202, 1,22,32'hA2,  1,3,32'h202,  0,0,2));
    step(mk(0, 1,4,32'h203, 1,22,32'hA2,  1,4,32'h203,  0,0,2));
    step(mk(0, 1,5,32'h204, 1,22,32'hA2,  1,5,32'h204,  0,0,2));
    step(mk(0, 1,6,32'h205, 1,22,32'hA2,  1,20,32'hA0,  0,1,2));
    step(mk(0, 1,6,32'h205, 1,22,32'hA2,  1,21,32'hA1,  1,1,1));
    step(mk(0, 1,6,32'h205, 0,0,0,        1,22,32'hA2,  1,1,1));
    step(mk(0, 1,6,32'h205, 0,0,0,        1,6,32'h205,  1,0,0));

    // reset in the middle of DRAIN drops the queued entry
    step(mk(0, 1,1,32'h300, 1,24,32'hB0,  1,1,32'h300,  1,0,0));
    step(mk(0, 1,2,32'h301, 1,25,32'hB1,  1,2,32'h301,  1,0,1));
    step(mk(0, 1,3,32'h302, 0,0,0,        1,3,32'h302,  0,0,2));
    step(mk(0, 1,4,32'h303, 0,0,0,        1,4,32'h303,  0,0,2));
    step(mk(0, 1,5,32'h304, 0,0,0,        1,5,32'h304,  0,0,2));
    step(mk(0, 1,6,32'h305, 0,0,0,        1,24,32'hB0,  0,1,2));
    step(mk(1, 1,6,32'h305, 0,0,0,        0,0,0,        0,0,-1));
    step(mk(0, 0,0,0,       0,0,0,        0,0,0,        1,0,0));
    step(mk(0, 0,0,0,       0,0,0,        0,0,0,        1,0,0));

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
